// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: opcode class constants, instruction
// field bit positions, the decoded-instruction record carried through the
// two-entry output buffer, and the opcode-class helper function.
// Optional feature macro used by decode_stage: DECODE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int DEC_PC_W    = 32;
  localparam int DEC_INSTR_W = 32;

  localparam logic [4:0] OPC_DATA_PROC = 5'b10000;
  localparam logic [4:0] OPC_BRANCH    = 5'b10001;
  localparam logic [4:0] OPC_UNDEF     = 5'b11111;

  // Instruction field bit positions
  localparam int COND_HI   = 31;
  localparam int COND_LO   = 28;
  localparam int CLASS_HI  = 27;
  localparam int CLASS_LO  = 25;
  localparam int IMM_BIT   = 25;
  localparam int P_BIT     = 24;
  localparam int U_BIT     = 23;
  localparam int W_BIT     = 21;
  localparam int L_BIT     = 20;
  localparam int S_BIT     = 20;
  localparam int BOFF_HI   = 23;
  localparam int RN_HI     = 19;
  localparam int RN_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 12;
  localparam int DATA12_HI = 11;
  localparam int RM_HI     = 3;

  typedef struct packed {
    logic [4:0]          opcode;
    logic                immediate_operand;
    logic [11:0]         data12;
    logic [23:0]         branch_offset;
    logic [3:0]          rn_idx;
    logic [3:0]          rd_idx;
    logic [3:0]          rm_idx;
    logic [3:0]          cond;
    logic                set_flags;
    logic                undef;
    logic [DEC_PC_W-1:0] pc;
  } decoded_instr_t;

  // Opcode class from bits [27:25]; data transfers encode {0,L,U,P,W}.
  function automatic logic [4:0] classify_opcode(input logic [DEC_INSTR_W-1:0] instr);
    logic [4:0] opc;
    opc = OPC_UNDEF;
    case (instr[CLASS_HI:CLASS_LO])
      3'b000, 3'b001: opc = OPC_DATA_PROC;
      3'b010, 3'b011: opc = {1'b0, instr[L_BIT], instr[U_BIT], instr[P_BIT], instr[W_BIT]};
      3'b101:         opc = OPC_BRANCH;
      default:        opc = OPC_UNDEF;
    endcase
    return opc;
  endfunction

endpackage : decode_pkg

// File: rtl/instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational split of a raw 32-bit instruction into the fields the
// shifter and register file consume, bundled with the instruction's PC.
// Ports:
//   instr   in   raw instruction
//   pc      in   PC of instr
//   fields  out  decoded_instr_t record
// -----------------------------------------------------------------------------
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [DEC_INSTR_W-1:0] instr,
  input  logic [DEC_PC_W-1:0]    pc,
  output decoded_instr_t         fields
);

  logic [4:0] opc_s;

  assign opc_s = classify_opcode(instr);

  // Field extraction; S bit only has meaning for data-processing instructions.
  always_comb begin
    fields                   = '0;
    fields.opcode            = opc_s;
    fields.immediate_operand = instr[IMM_BIT];
    fields.data12            = instr[DATA12_HI:0];
    fields.branch_offset     = instr[BOFF_HI:0];
    fields.rn_idx            = instr[RN_HI:RN_LO];
    fields.rd_idx            = instr[RD_HI:RD_LO];
    fields.rm_idx            = instr[RM_HI:0];
    fields.cond              = instr[COND_HI:COND_LO];
    fields.undef             = (opc_s == OPC_UNDEF);
    fields.pc                = pc;
    if (opc_s == OPC_DATA_PROC) begin
      fields.set_flags = instr[S_BIT];
    end else begin
      fields.set_flags = 1'b0;
    end
  end

endmodule : instr_field_decode

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Decode pipeline stage upstream of the operand shifter. Incoming instructions
// are decoded combinationally and captured into a two-entry skid buffer (main
// entry drives the outputs, skid entry absorbs one extra accept while the main
// entry is back-pressured), so in_ready depends only on registered state.
// Optional feature macro: DECODE_PERF_CNT_EN adds decoded_count/stall_count.
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready / instr_in / pc_in   fetch-side handshake
//   flush                                    drop held and incoming work
//   out_valid / out_ready                    execute-side handshake
//   opcode, immediate_operand, data12, branch_offset, rn_idx, rd_idx,
//   rm_idx, cond, set_flags, undef, pc_out   decoded fields of main entry
//   decoded_count, stall_count               (DECODE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W    = DEC_PC_W,
  parameter int INSTR_W = DEC_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]        decoded_count,
  output logic [31:0]        stall_count,
`endif
  output logic [4:0]         opcode,
  output logic               immediate_operand,
  output logic [11:0]        data12,
  output logic [23:0]        branch_offset,
  output logic [3:0]         rn_idx,
  output logic [3:0]         rd_idx,
  output logic [3:0]         rm_idx,
  output logic [3:0]         cond,
  output logic               set_flags,
  output logic               undef,
  output logic [PC_W-1:0]    pc_out
);

  decoded_instr_t in_fields_s;
  decoded_instr_t main_d, main_q;
  decoded_instr_t skid_d, skid_q;
  logic           main_valid_d, main_valid_q;
  logic           skid_valid_d, skid_valid_q;
  logic           accept_s;
  logic           consume_s;

  instr_field_decode u_field_decode (
    .instr  (instr_in),
    .pc     (pc_in),
    .fields (in_fields_s)
  );

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept_s  = in_valid & ~skid_valid_q & ~flush;
  assign consume_s = main_valid_q & out_ready;

  // Buffer next-state: flush wins; skid refills main on consume; a new
  // instruction lands in main if it is free (or leaving), else in skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume_s) begin
      if (skid_valid_q) begin
        // accept_s cannot be set here because in_ready is low
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_d       = in_fields_s;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      if (main_valid_q) begin
        skid_d       = in_fields_s;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_fields_s;
        main_valid_d = 1'b1;
      end
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign opcode            = main_q.opcode;
  assign immediate_operand = main_q.immediate_operand;
  assign data12            = main_q.data12;
  assign branch_offset     = main_q.branch_offset;
  assign rn_idx            = main_q.rn_idx;
  assign rd_idx            = main_q.rd_idx;
  assign rm_idx            = main_q.rm_idx;
  assign cond              = main_q.cond;
  assign set_flags         = main_q.set_flags;
  assign undef             = main_q.undef;
  assign pc_out            = main_q.pc;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] decoded_count_d, decoded_count_q;
  logic [31:0] stall_count_d, stall_count_q;

  // Counters follow the raw output handshake and ignore flush; wrap naturally.
  always_comb begin
    if (consume_s) begin
      decoded_count_d = decoded_count_q + 32'd1;
    end else begin
      decoded_count_d = decoded_count_q;
    end
    if (main_valid_q && !out_ready) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      decoded_count_q <= 32'd0;
      stall_count_q   <= 32'd0;
    end else begin
      decoded_count_q <= decoded_count_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign decoded_count = decoded_count_q;
  assign stall_count   = stall_count_q;
`endif

endmodule : decode_stage

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic        immediate_operand;
  logic [11:0] data12;
  logic [23:0] branch_offset;
  logic [3:0]  rn_idx, rd_idx, rm_idx, cond;
  logic        set_flags;
  logic        undef;
  logic [31:0] pc_out;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] decoded_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int unsigned exp_dec   = 0;
  int unsigned exp_stall = 0;

  decode_stage dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instr_in          (instr_in),
    .pc_in             (pc_in),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
`ifdef DECODE_PERF_CNT_EN
    .decoded_count     (decoded_count),
    .stall_count       (stall_count),
`endif
    .opcode            (opcode),
    .immediate_operand (immediate_operand),
    .data12            (data12),
    .branch_offset     (branch_offset),
    .rn_idx            (rn_idx),
    .rd_idx            (rd_idx),
    .rm_idx            (rm_idx),
    .cond              (cond),
    .set_flags         (set_flags),
    .undef             (undef),
    .pc_out            (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference opcode class from the architectural rules
  function automatic logic [4:0] ref_opcode(input logic [31:0] i);
    int cls;
    cls = int'((i >> 25) & 32'd7);
    if (cls == 0 || cls == 1) return 5'b10000;
    if (cls == 5) return 5'b10001;
    if (cls == 2 || cls == 3) return {1'b0, i[20], i[23], i[24], i[21]};
    return 5'b11111;
  endfunction

  task automatic compare_all();
    logic [31:0] i;
    logic [4:0]  eo;
    check_eq("in_ready", in_ready, (mq.size() < 2));
    check_eq("out_valid", out_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      i  = mq[0].instr;
      eo = ref_opcode(i);
      check_eq("opcode", opcode, eo);
      check_eq("imm", immediate_operand, (i >> 25) & 32'd1);
      check_eq("data12", data12, i % 4096);
      check_eq("boff", branch_offset, i % (1 << 24));
      check_eq("rn", rn_idx, (i >> 16) & 32'hF);
      check_eq("rd", rd_idx, (i >> 12) & 32'hF);
      check_eq("rm", rm_idx, i & 32'hF);
      check_eq("cond", cond, i >> 28);
      check_eq("set_flags", set_flags, (eo == 5'b10000) ? ((i >> 20) & 32'd1) : 32'd0);
      check_eq("undef", undef, (eo == 5'b11111));
      check_eq("pc_out", pc_out, mq[0].pc);
    end
`ifdef DECODE_PERF_CNT_EN
    check_eq("decoded_count", decoded_count, exp_dec);
    check_eq("stall_count", stall_count, exp_stall);
`endif
  endtask

  // One clock: predict from pre-edge inputs/state, advance, then compare.
  task automatic cycle();
    bit   acc, con, stl;
    ent_t e;
    acc = in_valid && (mq.size() < 2) && !flush;
    con = (mq.size() > 0) && out_ready;
    stl = (mq.size() > 0) && !out_ready;
    e.instr = instr_in;
    e.pc    = pc_in;
    @(posedge clk);
    if (con) exp_dec++;
    if (stl) exp_stall++;
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit f, input bit r);
    in_valid  = v;
    instr_in  = ins;
    pc_in     = pc;
    flush     = f;
    out_ready = r;
    cycle();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; instr_in = 32'h0; pc_in = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_opcode", opcode, 5'b00000);
    check_eq("rst_undef", undef, 1'b0);
    check_eq("rst_data12", data12, 12'h000);
    check_eq("rst_pc_out", pc_out, 32'h0);
    #9 reset = 1'b1;

    // Data-proc immediate, branch, load, undefined
    drive(1'b1, 32'hE3A01005, 32'h100, 1'b0, 1'b1);
    check_eq("dp_valid", out_valid, 1'b1);
    check_eq("dp_opcode", opcode, 5'b10000);
    check_eq("dp_imm", immediate_operand, 1'b1);
    check_eq("dp_data12", data12, 12'h005);
    check_eq("dp_rd", rd_idx, 4'd1);
    check_eq("dp_cond", cond, 4'hE);
    drive(1'b1, 32'hEAFFFFFE, 32'h104, 1'b0, 1'b1);
    check_eq("br_opcode", opcode, 5'b10001);
    check_eq("br_offset", branch_offset, 24'hFFFFFE);
    drive(1'b1, 32'hE5912004, 32'h108, 1'b0, 1'b1);
    check_eq("ld_opcode", opcode, 5'b01110);
    check_eq("ld_imm", immediate_operand, 1'b0);
    check_eq("ld_rn", rn_idx, 4'd1);
    check_eq("ld_rd", rd_idx, 4'd2);
    check_eq("ld_data12", data12, 12'h004);
    drive(1'b1, 32'hEE000000, 32'h10C, 1'b0, 1'b1);
    check_eq("ud_opcode", opcode, 5'b11111);
    check_eq("ud_undef", undef, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("drain_valid", out_valid, 1'b0);

    // Backpressure: three ADDs with out_ready low, then release
    drive(1'b1, 32'hE0821003, 32'h200, 1'b0, 1'b0);
    check_eq("bp_ready1", in_ready, 1'b1);
    drive(1'b1, 32'hE0831004, 32'h204, 1'b0, 1'b0);
    check_eq("bp_ready2", in_ready, 1'b0);
    check_eq("bp_rm_hold", rm_idx, 4'd3);
    drive(1'b1, 32'hE0841005, 32'h208, 1'b0, 1'b0);
    check_eq("bp_rm_hold2", rm_idx, 4'd3);
    drive(1'b1, 32'hE0841005, 32'h208, 1'b0, 1'b1);
    check_eq("bp_second", rm_idx, 4'd4);
    drive(1'b1, 32'hE0841005, 32'h208, 1'b0, 1'b1);
    check_eq("bp_third", rm_idx, 4'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("bp_empty", out_valid, 1'b0);

    // Flush with two held and a new offer
    drive(1'b1, 32'hE0821003, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'hE0831004, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'hE3A02007, 32'h308, 1'b1, 1'b0);
    check_eq("fl_valid", out_valid, 1'b0);
    check_eq("fl_ready", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("fl_dropped", out_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 32'hE3A01005, 32'h400, 1'b0, 1'b0);
    drive(1'b1, 32'hE3A01006, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("ar_out_valid", out_valid, 1'b0);
    check_eq("ar_opcode", opcode, 5'b00000);
    check_eq("ar_in_ready", in_ready, 1'b1);
`ifdef DECODE_PERF_CNT_EN
    check_eq("ar_dec_cnt", decoded_count, 32'd0);
    check_eq("ar_stall_cnt", stall_count, 32'd0);
`endif
    mq.delete();
    exp_dec   = 0;
    exp_stall = 0;
    #10 reset = 1'b1;

    for (int n = 0; n < 200; n++) begin
      drive($urandom_range(0, 1) != 0, $urandom, $urandom,
            $urandom_range(0, 49) == 0, $urandom_range(0, 1) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decode_stage
